// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Drives one active-low row at a time, samples synchronized columns on each
// scan tick, and reports the accepted key code, a held flag, a one-clock
// press strobe and a 7-segment image of the last accepted key.
//
// Handshake: there is no back-pressure. key_pulse is a one-clock valid strobe
// that coincides with FLAG rising; TECLA and DISP are stable from that cycle
// until the next accepted press, so a consumer may sample them on key_pulse.
module keypad_scan_debounce #(
    parameter int FPGAFREQ       = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [3:0] COLUMNAS,
    output logic [3:0] FILAS,
    output logic [3:0] TECLA,
    output logic       FLAG,
    output logic       key_pulse,
    output logic [7:0] DISP,
    output logic [1:0] state_o
);

    localparam int TICK_DIV = FPGAFREQ / SCAN_HZ;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W    = $clog2(DEBOUNCE_SCANS) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    logic [DIV_W-1:0] div_q;
    logic             tick;

    logic [3:0] col_meta_q;
    logic [3:0] col_sync_q;

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] cand_col_q, cand_col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0] tecla_q, tecla_d;
    logic       flag_q, flag_d;
    logic       pulse_q, pulse_d;
    logic [7:0] disp_q, disp_d;

    logic [3:0] col_low;
    logic       any_low;
    logic [1:0] first_col;
    logic       cand_low;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0] new_code;

    // Key code for the (row, column) intersection of the keypad.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Active-low hex font, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    function automatic logic [7:0] hex7(input logic [3:0] v);
        logic [7:0] seg;
        case (v)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    assign tick = (div_q == DIV_LAST);

    // Free-running scan-rate divider; tick marks its terminal count.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous, pulled-up column inputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= COLUMNAS;
            col_sync_q <= col_meta_q;
        end
    end

    assign col_low  = ~col_sync_q;
    assign any_low  = |col_low;
    assign cand_low = col_low[cand_col_q];
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign new_code = key_code(row_q, cand_col_q);

    // Lowest-index low column wins when several keys share a row.
    always_comb begin
        first_col = 2'd0;
        if (col_low[0]) begin
            first_col = 2'd0;
        end else if (col_low[1]) begin
            first_col = 2'd1;
        end else if (col_low[2]) begin
            first_col = 2'd2;
        end else if (col_low[3]) begin
            first_col = 2'd3;
        end
    end

    // Scan FSM state and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_SCAN;
            row_q      <= 2'd0;
            cand_col_q <= 2'd0;
            cnt_q      <= '0;
            tecla_q    <= 4'h0;
            flag_q     <= 1'b0;
            pulse_q    <= 1'b0;
            disp_q     <= 8'hFF;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cand_col_q <= cand_col_d;
            cnt_q      <= cnt_d;
            tecla_q    <= tecla_d;
            flag_q     <= flag_d;
            pulse_q    <= pulse_d;
            disp_q     <= disp_d;
        end
    end

    // Next-state logic; everything advances only on scan ticks.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        cand_col_d = cand_col_q;
        cnt_d      = cnt_q;
        tecla_d    = tecla_q;
        flag_d     = flag_q;
        pulse_d    = 1'b0;
        disp_d     = disp_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low) begin
                        // Freeze the row and start confirming this column.
                        cand_col_d = first_col;
                        cnt_d      = '0;
                        state_d    = ST_DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (cand_low) begin
                        if (cnt_q >= DB_LAST) begin
                            state_d = ST_PRESSED;
                            flag_d  = 1'b1;
                            pulse_d = 1'b1;
                            tecla_d = new_code;
                            disp_d  = hex7(new_code);
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (!cand_low) begin
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    if (!cand_low) begin
                        if (cnt_q >= DB_LAST) begin
                            // Rotation resumes from the frozen row.
                            flag_d  = 1'b0;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    assign FILAS     = ~(4'b0001 << row_q);
    assign TECLA     = tecla_q;
    assign FLAG      = flag_q;
    assign key_pulse = pulse_q;
    assign DISP      = disp_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce: a keypad model answers the scanned rows,
// stimulus pushes expected press/release events into a queue, and a monitor
// pops and compares them whenever the DUT reports a press or a release.
module tb_keypad_scan_debounce;

    localparam int FPGAFREQ = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int DS       = 3;
    localparam int TICK     = FPGAFREQ / SCAN_HZ;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    logic [3:0]  columnas;
    logic [3:0]  filas;
    logic [3:0]  tecla;
    logic        flag;
    logic        key_pulse;
    logic [7:0]  disp;
    logic [1:0]  dbg_state;

    // keys[r*4+c] = 1 means the key at row r, column c is held down.
    logic [15:0] keys;

    logic [7:0]  font [16];
    logic [3:0]  keymap [16];

    logic [12:0] exp_q[$];   // {kind(1=press,0=release), code, disp image}

    int checks = 0;
    int errors = 0;

    keypad_scan_debounce #(
        .FPGAFREQ       (FPGAFREQ),
        .SCAN_HZ        (SCAN_HZ),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .COLUMNAS  (columnas),
        .FILAS     (filas),
        .TECLA     (tecla),
        .FLAG      (flag),
        .key_pulse (key_pulse),
        .DISP      (disp),
        .state_o   (dbg_state)
    );

    // Passive matrix: a column is pulled low when a held key sits on the driven row.
    always_comb begin
        columnas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!filas[r] && keys[r*4+c]) columnas[c] = 1'b0;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic kind, input int k);
        exp_q.push_back({kind, keymap[k], font[keymap[k]]});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic        flag_prev;
        logic        rose;
        logic        fell;
        logic [12:0] e;
        flag_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (nreset === 1'b1) begin
                rose = flag && !flag_prev;
                fell = !flag && flag_prev;
                if (key_pulse || rose) begin
                    check("pulse_on_flag_rise", {30'd0, key_pulse, rose}, 32'd3);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_press: got key %0h expected no event", tecla);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_press", {31'd0, e[12]}, 32'd1);
                        check("press_tecla", {28'd0, tecla}, {28'd0, e[11:8]});
                        check("press_disp", {24'd0, disp}, {24'd0, e[7:0]});
                    end
                end
                if (fell) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_release: got key %0h expected no event", tecla);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_release", {31'd0, e[12]}, 32'd0);
                        check("release_tecla", {28'd0, tecla}, {28'd0, e[11:8]});
                    end
                end
                flag_prev = flag;
            end else begin
                flag_prev = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int          n;
        int          k;
        logic [3:0]  prev_filas;
        logic [3:0]  exp_filas;
        logic [1:0]  row_idx;
        logic [12:0] e;

        font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'hE, 4'h0, 4'hF, 4'hD};
        keys   = 16'h0;
        nreset = 1'b0;

        // Reset values.
        wait_clk(3);
        check("rst_filas", {28'd0, filas}, 32'hE);
        check("rst_tecla", {28'd0, tecla}, 32'h0);
        check("rst_flag", {31'd0, flag}, 32'd0);
        check("rst_pulse", {31'd0, key_pulse}, 32'd0);
        check("rst_disp", {24'd0, disp}, 32'hFF);
        check("rst_state_scan", {30'd0, dbg_state}, 32'd0);

        // Idle rotation: one row per 10 clocks starting from row 0.
        nreset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            row_idx   = 2'(((i + 1) / TICK) % 4);
            exp_filas = ~(4'b0001 << row_idx);
            check("idle_filas", {28'd0, filas}, {28'd0, exp_filas});
        end
        check("idle_flag", {31'd0, flag}, 32'd0);
        check("idle_disp", {24'd0, disp}, 32'hFF);
        check("idle_tecla", {28'd0, tecla}, 32'h0);

        // Key 5 pressed the moment row 1 becomes active: exact latency.
        prev_filas = filas;
        n = 0;
        while (!(filas == 4'b1101 && prev_filas != 4'b1101) && n < 100) begin
            prev_filas = filas;
            @(negedge clk);
            n++;
        end
        check("row1_reached", {31'd0, (n < 100)}, 32'd1);
        keys[5] = 1'b1;
        push_ev(1'b1, 5);
        n = 0;
        while (flag !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", n, (DS + 1) * TICK);
        check("press5_filas_frozen", {28'd0, filas}, 32'hD);
        check("press5_tecla", {28'd0, tecla}, 32'h5);
        check("press5_disp", {24'd0, disp}, 32'h92);

        // One-tick release bounce while held: no new pulse, FLAG stays.
        wait_clk(3 * TICK);
        keys[5] = 1'b0;
        wait_clk(TICK);
        keys[5] = 1'b1;
        wait_clk(5 * TICK);
        check("bounce_flag_held", {31'd0, flag}, 32'd1);
        check("bounce_filas_frozen", {28'd0, filas}, 32'hD);

        // Clean release, tick-aligned: exact release latency.
        keys[5] = 1'b0;
        push_ev(1'b0, 5);
        n = 0;
        while (flag !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("release_latency", n, (DS + 1) * TICK);

        // One-tick glitch on key 5: nothing accepted.
        wait_clk(TICK);
        keys[5] = 1'b1;
        wait_clk(TICK);
        keys[5] = 1'b0;
        wait_clk(6 * TICK);
        check("glitch_flag", {31'd0, flag}, 32'd0);
        check("glitch_tecla", {28'd0, tecla}, 32'h5);
        check("glitch_disp", {24'd0, disp}, 32'h92);

        // Keys 3 and A together: lowest column wins; key 0 ignored while held.
        keys[2] = 1'b1;
        keys[3] = 1'b1;
        push_ev(1'b1, 2);
        wait_clk(14 * TICK);
        keys[13] = 1'b1;
        wait_clk(10 * TICK);
        check("multi_tecla", {28'd0, tecla}, 32'h3);
        check("multi_disp", {24'd0, disp}, 32'hB0);
        check("multi_flag", {31'd0, flag}, 32'd1);
        keys[2] = 1'b0;
        keys[3] = 1'b0;
        push_ev(1'b0, 2);
        push_ev(1'b1, 13);
        wait_clk(20 * TICK);
        check("key0_tecla", {28'd0, tecla}, 32'h0);
        check("key0_disp", {24'd0, disp}, 32'hC0);
        check("key0_flag", {31'd0, flag}, 32'd1);
        keys[13] = 1'b0;
        push_ev(1'b0, 13);
        wait_clk(8 * TICK);

        // Asynchronous reset while A is held, then re-debounce of A.
        keys[3] = 1'b1;
        push_ev(1'b1, 3);
        wait_clk(14 * TICK);
        check("preA_flag", {31'd0, flag}, 32'd1);
        check("preA_tecla", {28'd0, tecla}, 32'hA);
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_rst_filas", {28'd0, filas}, 32'hE);
        check("async_rst_tecla", {28'd0, tecla}, 32'h0);
        check("async_rst_flag", {31'd0, flag}, 32'd0);
        check("async_rst_pulse", {31'd0, key_pulse}, 32'd0);
        check("async_rst_disp", {24'd0, disp}, 32'hFF);
        wait_clk(2);
        push_ev(1'b1, 3);
        #2 nreset = 1'b1;
        wait_clk(14 * TICK);
        check("postrst_tecla", {28'd0, tecla}, 32'hA);
        check("postrst_disp", {24'd0, disp}, 32'h88);
        keys[3] = 1'b0;
        push_ev(1'b0, 3);
        wait_clk(8 * TICK);

        // Randomized presses with optional bounce on either edge.
        for (int it = 0; it < 12; it++) begin
            k = int'($urandom_range(0, 15));
            wait_clk(int'($urandom_range(0, TICK - 1)));
            push_ev(1'b1, k);
            if ($urandom_range(0, 1) == 1) begin
                keys[k] = 1'b1;
                wait_clk(TICK);
                keys[k] = 1'b0;
                wait_clk(TICK);
            end
            keys[k] = 1'b1;
            wait_clk(TICK * int'($urandom_range(14, 18)));
            push_ev(1'b0, k);
            if ($urandom_range(0, 1) == 1) begin
                keys[k] = 1'b0;
                wait_clk(TICK);
                keys[k] = 1'b1;
                wait_clk(TICK);
            end
            keys[k] = 1'b0;
            wait_clk(TICK * int'($urandom_range(8, 10)));
        end

        // Every expected event must have been observed.
        wait_clk(5 * TICK);
        check("queue_drained", exp_q.size(), 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("FAIL missing_event: got nothing expected kind %0d key %0h", e[12], e[11:8]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Scans a 4x4 matrix keypad, debounces key presses and releases, and produces the key code, a held-key flag and a one-clock press strobe.
- Also produces a 7-segment image of the last key.
- Feeds the game/VGA top, which moves players and fires bullets on the rising edge of FLAG with TECLA.
- Produces the same TECLA/FLAG/DISP contract the top consumes, so it drops in on the keypad side.

Parameters:
- FPGAFREQ, 50_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, row-advance/sample tick rate in Hz; tick period = FPGAFREQ/SCAN_HZ clocks.
- DEBOUNCE_SCANS, 20, consecutive stable ticks required to accept a press or a release.

Ports:
- clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- COLUMNAS  in  4  keypad columns, active-low, externally pulled up, asynchronous.
- FILAS  out  4  keypad rows, active-low; exactly one bit is low.
- TECLA  out  4  code of the accepted key; held until the next accepted press.
- FLAG  out  1  high while the accepted key is held, after press debounce until release debounce.
- key_pulse  out  1  one-clock strobe on the cycle FLAG rises.
- DISP  out  8  7-segment image of TECLA, active-low, bit order {dp,g,f,e,d,c,b,a}; dp is always 1.

Behaviour:
- Reset (async assert, sync release): FILAS=4'b1110 (row 0), TECLA=0, FLAG=0, key_pulse=0, DISP=8'hFF (blank), FSM=SCAN, all counters 0.
- Tick: free-running divider counts 0..FPGAFREQ/SCAN_HZ-1; tick is high for 1 clk at the terminal count.
- COLUMNAS passes through a 2-FF synchronizer before use; the FSM uses synchronized values only.
- Key map, row r (FILAS bit r low), column c (COLUMNAS bit c low):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *=E, 0, #=F, D
- Multiple columns low: the lowest column index wins.
- The FSM acts only on tick cycles:
  - SCAN: sample the columns for the current row. If any is low, latch row/col into a candidate, clear the debounce counter, go to DEBOUNCE and freeze FILAS. Otherwise rotate FILAS to the next row (r3 wraps to r0). A row is driven for one full tick before it is sampled.
  - DEBOUNCE: if the candidate column is still low, increment the counter. When the counter reaches DEBOUNCE_SCANS-1, go to PRESSED: TECLA<=candidate code, FLAG<=1, key_pulse=1 for one clk, DISP updated on the same clk. If the candidate column is high, return to SCAN with FLAG unchanged (0).
  - PRESSED: FILAS stays frozen. If the candidate column is high, clear the counter and go to RELEASE. Other keys are ignored; no rollover.
  - RELEASE: if the candidate column is high, increment the counter. When the counter reaches DEBOUNCE_SCANS-1, FLAG<=0 and go to SCAN, resuming rotation from the frozen row. If the column goes low again, return to PRESSED with no new pulse and FLAG staying 1.
- Press latency: first low sample to FLAG=1 is DEBOUNCE_SCANS ticks, ±1 tick of scan phase plus 2 clk synchronizer delay.
- TECLA and DISP persist after release.
- DISP uses the standard hex font. Examples: 0=C0, 1=F9, 5=92, 9=90, A=88, B=83, E=86, F=8E.
- Counter width is $clog2(DEBOUNCE_SCANS)+1 and saturates; it never wraps.
- nreset asserted mid-press: immediately returns to the reset state. A key still held after reset is re-debounced from SCAN and produces a new pulse.
- DEBOUNCE_SCANS=1: a press is accepted on the first confirming tick.

Test Plan:
(Bench parameters: FPGAFREQ=1000, SCAN_HZ=100 (tick every 10 clk), DEBOUNCE_SCANS=3.)
- Reset, no key, 100 clk -> FILAS cycles 1110,1101,1011,0111,1110 every 10 clk; FLAG=0; DISP=FF; TECLA=0.
- Hold row1/col1 (key 5) low whenever FILAS[1]=0 -> FILAS freezes at 1101; after 3 ticks FLAG=1, TECLA=5, DISP=92, key_pulse high exactly 1 clk.
- Key 5 glitch: low for 1 tick, then high -> return to SCAN; FLAG, key_pulse and TECLA unchanged.
- Release key 5 for 1 tick, re-press, hold, then release for 3 ticks -> FLAG stays 1 with no second pulse during the bounce; FLAG=0 after 3 clean ticks; TECLA stays 5; scanning resumes.
- Press row0 col2 and col3 together (3 and A) -> TECLA=3, DISP=B0. Then press row3/col1 (key 0) while 3 is held -> ignored; after 3 is released, key 0 is accepted with TECLA=0, DISP=C0.
- Assert nreset while FLAG=1 with key A held -> outputs return to reset values asynchronously. Release nreset with A still held -> A re-debounced, TECLA=A, DISP=88, one key_pulse.
